// File: rtl/mimo_rr_scheduler.sv
// mimo_rr_scheduler: drains eight buffered write streams onto one shared memory
// write bus using bounded-burst round-robin (at most MAX_BURST back-to-back grants
// per stream while others wait). Output stage is registered, latency 1 from grant.
// Optional statistics outputs are compiled in with `define MIMO_RR_SCHEDULER_STATS_EN.
module mimo_rr_scheduler #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [8*(WIDTH+3)-1:0] i_stream_data,
    input  logic [7:0]             i_stream_valid,
    output logic [7:0]             o_stream_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [7:0]             o_valid,
    output logic [2:0]             o_src,
    output logic                   o_busy
`ifdef MIMO_RR_SCHEDULER_STATS_EN
    ,
    output logic [31:0]            o_grant_count,
    output logic [7:0]             o_starve_max
`endif
);

    localparam int unsigned SW         = WIDTH + 3;
    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_HOLD    = 1'b1;
    localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST);

    logic [0:0]    state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    owner_q, owner_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          grant;
    logic [2:0]    grant_idx;
    logic [7:0]    grant_vec;
    logic [3:0]    hit_ptr, hit_next;
    logic [SW-1:0] streams [8];
    logic [SW-1:0] sel;

    // {found, index} of the first valid stream at or after start, wrapping mod 8.
    function automatic logic [3:0] search(input logic [7:0] valid, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        // Walk backwards so the smallest offset from start is the last to win.
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Unpack the flat stream bus and pick the granted stream.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            streams[k] = i_stream_data[k*SW +: SW];
        end
        sel = streams[grant_idx];
    end

    // Arbitration: next-state and the single combinational grant.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        grant_idx = 3'd0;
        hit_ptr   = search(i_stream_valid, ptr_q);
        hit_next  = search(i_stream_valid, owner_q + 3'd1);
        if (i_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_ptr[3]) begin
                        grant     = 1'b1;
                        grant_idx = hit_ptr[2:0];
                        owner_d   = hit_ptr[2:0];
                        cnt_d     = 8'd1;
                        if (MAX_BURST == 1) ptr_d = hit_ptr[2:0] + 3'd1;
                        else                state_d = ST_HOLD;
                    end
                end
                default: begin
                    if (i_stream_valid[owner_q]) begin
                        grant     = 1'b1;
                        grant_idx = owner_q;
                        cnt_d     = cnt_q + 8'd1;
                        if (cnt_d == BURST_LAST) begin
                            ptr_d   = owner_q + 3'd1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Owner ran dry: hand over in the same cycle, no bubble.
                        ptr_d = owner_q + 3'd1;
                        if (hit_next[3]) begin
                            grant     = 1'b1;
                            grant_idx = hit_next[2:0];
                            owner_d   = hit_next[2:0];
                            cnt_d     = 8'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
        end
        grant_vec = grant ? (8'b1 << grant_idx) : 8'b0;
    end

    // Pop strobe is suppressed while reset is held.
    always_comb begin
        o_stream_ready = i_reset ? 8'b0 : grant_vec;
    end

    // Scheduler state and registered write-bus outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            owner_q <= 3'd0;
            cnt_q   <= 8'd0;
            o_data  <= '0;
            o_valid <= 8'b0;
            o_src   <= 3'd0;
            o_busy  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            o_busy  <= (state_d == ST_HOLD);
            if (grant) begin
                o_data  <= sel[WIDTH-1:0];
                o_valid <= 8'b1 << sel[SW-1:WIDTH];
                o_src   <= grant_idx;
            end else begin
                o_data  <= '0;
                o_valid <= 8'b0;
            end
        end
    end

`ifdef MIMO_RR_SCHEDULER_STATS_EN
    logic [7:0]  wait_q [8];
    logic [7:0]  wait_d [8];
    logic [7:0]  starve_d;
    logic [31:0] grant_count_q;
    logic [7:0]  starve_max_q;

    // Per-stream wait run lengths (frozen while disabled) and their running maximum.
    always_comb begin
        starve_d = starve_max_q;
        for (int k = 0; k < 8; k++) begin
            wait_d[k] = wait_q[k];
            if (i_enable) begin
                if (i_stream_valid[k] && !grant_vec[k]) begin
                    wait_d[k] = (wait_q[k] == 8'hFF) ? 8'hFF : wait_q[k] + 8'd1;
                end else begin
                    wait_d[k] = 8'd0;
                end
            end
            if (wait_d[k] > starve_d) starve_d = wait_d[k];
        end
    end

    // Saturating grant counter and starvation statistics.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            grant_count_q <= 32'd0;
            starve_max_q  <= 8'd0;
            for (int k = 0; k < 8; k++) wait_q[k] <= 8'd0;
        end else begin
            if (grant && grant_count_q != 32'hFFFF_FFFF) grant_count_q <= grant_count_q + 32'd1;
            starve_max_q <= starve_d;
            for (int k = 0; k < 8; k++) wait_q[k] <= wait_d[k];
        end
    end

    assign o_grant_count = grant_count_q;
    assign o_starve_max  = starve_max_q;
`endif

endmodule

// File: tb/tb_mimo_rr_scheduler.sv
// Directed bench for mimo_rr_scheduler: burst round-robin, MAX_BURST=1 alternation,
// owner hand-over, enable pause, async reset mid-burst and tag/data routing.
module tb_mimo_rr_scheduler;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SW    = WIDTH + 3;

    logic               i_clock;
    logic               i_reset;
    logic               i_enable;
    logic [8*SW-1:0]    i_stream_data;
    logic [7:0]         i_stream_valid;

    logic [7:0]         ready4, ready1;
    logic [WIDTH-1:0]   data4, data1;
    logic [7:0]         valid4, valid1;
    logic [2:0]         src4, src1;
    logic               busy4, busy1;
`ifdef MIMO_RR_SCHEDULER_STATS_EN
    logic [31:0]        gcnt4, gcnt1;
    logic [7:0]         smax4, smax1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mimo_rr_scheduler #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_stream_data  (i_stream_data),
        .i_stream_valid (i_stream_valid),
        .o_stream_ready (ready4),
        .o_data         (data4),
        .o_valid        (valid4),
        .o_src          (src4),
        .o_busy         (busy4)
`ifdef MIMO_RR_SCHEDULER_STATS_EN
        ,
        .o_grant_count  (gcnt4),
        .o_starve_max   (smax4)
`endif
    );

    mimo_rr_scheduler #(.WIDTH(WIDTH), .MAX_BURST(1)) dut1 (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_stream_data  (i_stream_data),
        .i_stream_valid (i_stream_valid),
        .o_stream_ready (ready1),
        .o_data         (data1),
        .o_valid        (valid1),
        .o_src          (src1),
        .o_busy         (busy1)
`ifdef MIMO_RR_SCHEDULER_STATS_EN
        ,
        .o_grant_count  (gcnt1),
        .o_starve_max   (smax1)
`endif
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reset for one edge; returns 2 time units after the first edge with reset released.
    task automatic apply_reset();
        i_reset = 1'b1;
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge i_clock);
        #2;
    endtask

    int exp_g, prev_g;

    initial begin
        i_reset        = 1'b1;
        i_enable       = 1'b1;
        i_stream_valid = 8'hFF;
        for (int k = 0; k < 8; k++) i_stream_data[k*SW +: SW] = {3'(k), 16'(16'h1000 + k)};

        // Reset state, with every stream valid.
        #2;
        check("rst_ready", 32'(ready4), 32'h0);
        check("rst_valid", 32'(valid4), 32'h0);
        check("rst_data",  32'(data4),  32'h0);
        check("rst_src",   32'(src4),   32'h0);
        check("rst_busy",  32'(busy4),  32'h0);
`ifdef MIMO_RR_SCHEDULER_STATS_EN
        check("rst_gcnt",  gcnt4,       32'h0);
        check("rst_smax",  32'(smax4),  32'h0);
`endif

        // All streams valid, bursts of 4: 0,0,0,0,1,...,7,7,7,7,0.
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        #1;
        for (int c = 0; c <= 32; c++) begin
            exp_g = (c / 4) % 8;
            check("rr_ready", 32'(ready4), 32'(1) << exp_g);
            check("rr_busy",  32'(busy4),  (c % 4 != 0) ? 32'd1 : 32'd0);
            if (c > 0) begin
                prev_g = ((c - 1) / 4) % 8;
                check("rr_valid", 32'(valid4), 32'(1) << prev_g);
                check("rr_src",   32'(src4),   32'(prev_g));
                check("rr_data",  32'(data4),  32'h1000 + 32'(prev_g));
            end
            next_cycle();
        end

        // MAX_BURST=1 with streams 2 and 5: strict alternation, never busy.
        i_stream_valid = 8'b0010_0100;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            check("mb1_ready", 32'(ready1), (c % 2 == 0) ? 32'h04 : 32'h20);
            check("mb1_busy",  32'(busy1),  32'h0);
            next_cycle();
        end

        // Stream 3 holds two entries, stream 6 valid: 3,3,6 with no gap.
        i_stream_valid = 8'b0100_1000;
        apply_reset();
        check("ho_ready0", 32'(ready4), 32'h08);
        next_cycle();
        check("ho_ready1", 32'(ready4), 32'h08);
        @(posedge i_clock);
        #1 i_stream_valid = 8'b0100_0000;
        #1;
        check("ho_ready2", 32'(ready4), 32'h40);
        check("ho_busy2",  32'(busy4),  32'h1);
        check("ho_valid2", 32'(valid4), 32'h08);
        @(posedge i_clock);
        #1 i_stream_valid = 8'b1100_0000;
        #1;
        check("ho_ptr",    32'(dut.ptr_q), 32'd4);
        check("ho_ready3", 32'(ready4), 32'h40);
        check("ho_valid3", 32'(valid4), 32'h40);

        // Pause for 5 cycles with owner 6 at cnt=2; burst then finishes with two more.
        @(posedge i_clock);
        #1 i_enable = 1'b0;
        #1;
        for (int p = 0; p < 5; p++) begin
            check("pause_ready", 32'(ready4), 32'h0);
            if (p > 0) check("pause_valid", 32'(valid4), 32'h0);
            @(posedge i_clock);
            #1;
            if (p == 4) i_enable = 1'b1;
            #1;
        end
        check("res_ready_a", 32'(ready4), 32'h40);
        check("res_valid_a", 32'(valid4), 32'h0);
        check("res_busy_a",  32'(busy4),  32'h1);
        next_cycle();
        check("res_ready_b", 32'(ready4), 32'h40);
        next_cycle();
        check("res_ready_c", 32'(ready4), 32'h80);
        check("res_busy_c",  32'(busy4),  32'h0);
        check("res_valid_c", 32'(valid4), 32'h40);
        next_cycle();
        check("res_ready_d", 32'(ready4), 32'h80);
        check("res_busy_d",  32'(busy4),  32'h1);
        check("res_valid_d", 32'(valid4), 32'h80);
        next_cycle();
        check("own7_valid",  32'(valid4), 32'h80);

        // Asynchronous reset between edges while stream 7 owns the bus.
        #3 i_reset = 1'b1;
        #1;
        check("arst_valid", 32'(valid4), 32'h0);
        check("arst_data",  32'(data4),  32'h0);
        check("arst_ready", 32'(ready4), 32'h0);
        check("arst_busy",  32'(busy4),  32'h0);
        i_stream_valid = 8'b1000_0001;
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        #1;
        check("arst_first", 32'(ready4), 32'h01);

        // Stream 1 carrying tag 5 / data 0xABCD.
        i_stream_valid = 8'b0000_0010;
        i_stream_data[1*SW +: SW] = {3'd5, 16'hABCD};
        apply_reset();
        check("tag_ready", 32'(ready4), 32'h02);
        @(posedge i_clock);
        #1 i_stream_valid = 8'b0;
        #1;
        check("tag_data",  32'(data4),  32'hABCD);
        check("tag_valid", 32'(valid4), 32'h20);
        check("tag_src",   32'(src4),   32'h1);
`ifdef MIMO_RR_SCHEDULER_STATS_EN
        check("tag_gcnt",  gcnt4,       32'h1);
`endif
        next_cycle();
        check("idle_data",  32'(data4),  32'h0);
        check("idle_valid", 32'(valid4), 32'h0);
        check("idle_src",   32'(src4),   32'h1);
        check("idle_ready", 32'(ready4), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
